// File: rtl/dlsc_dma_command_sequencer.sv
// DMA command sequencer: fetches two-word {address, length} commands from a
// shared read/write command FIFO pair and presents them on independent
// valid/ready channels. Zero-length commands are popped and dropped.
`timescale 1ns/1ps

module dlsc_dma_command_sequencer #(
  parameter int LENB = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            cmd_sel,
  output logic            cmd_pop,
  output logic            cmd_lsb,
  input  logic [31:0]     cmd_rd_data,
  input  logic            cmd_stall,
  input  logic            frd_empty,
  input  logic            fwr_empty,
  output logic            rd_cmd_valid,
  input  logic            rd_cmd_ready,
  output logic [31:0]     rd_cmd_addr,
  output logic [LENB-1:0] rd_cmd_len,
  output logic            wr_cmd_valid,
  input  logic            wr_cmd_ready,
  output logic [31:0]     wr_cmd_addr,
  output logic [LENB-1:0] wr_cmd_len,
  output logic            cmd_drop
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ_LO, ST_REQ_HI, ST_CAP} state_t;

  state_t            state_q, state_d;
  logic              chan_q, chan_d;
  logic              last_q, last_d;
  logic [31:0]       lo_q, lo_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  logic [LENB-1:0]   rd_len_q, rd_len_d;
  logic              wr_valid_q, wr_valid_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [LENB-1:0]   wr_len_q, wr_len_d;

  logic elig_rd, elig_wr, len_zero;

  // A channel may be fetched only when it has a command and its output slot is free.
  assign elig_rd  = !frd_empty && !rd_valid_q;
  assign elig_wr  = !fwr_empty && !wr_valid_q;
  // During CAP the FIFO shows the hi word; only its low LENB bits are the length.
  assign len_zero = (cmd_rd_data[LENB-1:0] == '0);

  // State register: FSM state and selected channel.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      chan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  // Next-state logic: round-robin channel choice in IDLE, stall-aware fetch sequence.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_rd && elig_wr) begin
          chan_d  = !last_q;
          state_d = ST_REQ_LO;
        end else if (elig_rd) begin
          chan_d  = 1'b0;
          state_d = ST_REQ_LO;
        end else if (elig_wr) begin
          chan_d  = 1'b1;
          state_d = ST_REQ_LO;
        end
      end
      ST_REQ_LO: if (!cmd_stall) state_d = ST_REQ_HI;
      ST_REQ_HI: if (!cmd_stall) state_d = ST_CAP;
      ST_CAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO select, word select and pop, plus the drop pulse.
  always_comb begin
    cmd_sel  = chan_q;
    cmd_lsb  = (state_q == ST_REQ_HI);
    cmd_pop  = (state_q == ST_REQ_HI);
    cmd_drop = (state_q == ST_CAP) && len_zero;
  end

  // Datapath next values: address latch, arbitration history, output channels.
  always_comb begin
    lo_d       = lo_q;
    last_d     = last_q;
    rd_valid_d = rd_valid_q && !rd_cmd_ready;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    wr_valid_d = wr_valid_q && !wr_cmd_ready;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    // The lo word is visible while the hi word is being addressed.
    if (state_q == ST_REQ_HI && !cmd_stall) lo_d = cmd_rd_data;
    if (state_q == ST_CAP) begin
      last_d = chan_q;
      if (!len_zero) begin
        if (chan_q) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = lo_q;
          wr_len_d   = cmd_rd_data[LENB-1:0];
        end else begin
          rd_valid_d = 1'b1;
          rd_addr_d  = lo_q;
          rd_len_d   = cmd_rd_data[LENB-1:0];
        end
      end
    end
  end

  // Datapath registers.
  // NOTE: datapath flops are reset too, because addr/len must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q       <= '0;
      last_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
    end else begin
      lo_q       <= lo_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
    end
  end

  assign rd_cmd_valid = rd_valid_q;
  assign rd_cmd_addr  = rd_addr_q;
  assign rd_cmd_len   = rd_len_q;
  assign wr_cmd_valid = wr_valid_q;
  assign wr_cmd_addr  = wr_addr_q;
  assign wr_cmd_len   = wr_len_q;

endmodule

// File: tb/tb_dlsc_dma_command_sequencer.sv
// Bench for dlsc_dma_command_sequencer: models the command FIFO pair and keeps
// a per-channel scoreboard of pushed commands that every delivered/dropped
// command and every pop is checked against.
`timescale 1ns/1ps

module tb_dlsc_dma_command_sequencer;

  localparam int LENB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_sel, cmd_pop, cmd_lsb, cmd_drop;
  logic [31:0]     cmd_rd_data = 32'h0;
  logic            cmd_stall;
  logic            frd_empty = 1'b1;
  logic            fwr_empty = 1'b1;
  logic            rd_cmd_valid, rd_cmd_ready;
  logic [31:0]     rd_cmd_addr;
  logic [LENB-1:0] rd_cmd_len;
  logic            wr_cmd_valid, wr_cmd_ready;
  logic [31:0]     wr_cmd_addr;
  logic [LENB-1:0] wr_cmd_len;

  always #5 clk = ~clk;

  dlsc_dma_command_sequencer #(.LENB(LENB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_sel(cmd_sel), .cmd_pop(cmd_pop), .cmd_lsb(cmd_lsb),
    .cmd_rd_data(cmd_rd_data), .cmd_stall(cmd_stall),
    .frd_empty(frd_empty), .fwr_empty(fwr_empty),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
    .cmd_drop(cmd_drop)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] hi;
  } cmd_t;

  cmd_t frd_q[$], fwr_q[$];        // FIFO contents
  cmd_t exp_rd_q[$], exp_wr_q[$];  // commands not yet delivered or dropped
  int   hs_order[$];               // channel of each completed handshake

  int n_vec = 0, n_fail = 0;
  int pop_cnt = 0, drop_cnt = 0, rd_vcyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Length as defined by the command format: hi word modulo 2**LENB.
  function automatic logic [LENB-1:0] len_of(input cmd_t c);
    return LENB'(64'(c.hi) % (64'd1 << LENB));
  endfunction

  task automatic push(input bit ch, input logic [31:0] addr, input logic [31:0] hi);
    cmd_t c;
    c.addr = addr;
    c.hi   = hi;
    if (ch) begin fwr_q.push_back(c); exp_wr_q.push_back(c); end
    else    begin frd_q.push_back(c); exp_rd_q.push_back(c); end
  endtask

  // FIFO pair: registered read data and empty flags; stall blocks access and pop.
  always @(posedge clk) begin
    if (!cmd_stall) begin
      if (cmd_sel) begin
        if (fwr_q.size() > 0) begin
          cmd_rd_data <= cmd_lsb ? fwr_q[0].hi : fwr_q[0].addr;
          if (cmd_pop) void'(fwr_q.pop_front());
        end else cmd_rd_data <= 32'hDEAD_BEEF;
      end else begin
        if (frd_q.size() > 0) begin
          cmd_rd_data <= cmd_lsb ? frd_q[0].hi : frd_q[0].addr;
          if (cmd_pop) void'(frd_q.pop_front());
        end else cmd_rd_data <= 32'hDEAD_BEEF;
      end
    end
    frd_empty <= (frd_q.size() == 0);
    fwr_empty <= (fwr_q.size() == 0);
  end

  // Compare process: outputs against the scoreboard on every running cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_cmd_valid) begin
        rd_vcyc++;
        if (exp_rd_q.size() == 0) check("rd_unexpected_valid", 1, 0);
        else begin
          check("rd_addr", rd_cmd_addr, exp_rd_q[0].addr);
          check("rd_len", rd_cmd_len, len_of(exp_rd_q[0]));
          if (rd_cmd_ready) begin void'(exp_rd_q.pop_front()); hs_order.push_back(0); end
        end
      end
      if (wr_cmd_valid) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected_valid", 1, 0);
        else begin
          check("wr_addr", wr_cmd_addr, exp_wr_q[0].addr);
          check("wr_len", wr_cmd_len, len_of(exp_wr_q[0]));
          if (wr_cmd_ready) begin void'(exp_wr_q.pop_front()); hs_order.push_back(1); end
        end
      end
      if (cmd_drop) begin
        drop_cnt++;
        if (cmd_sel) begin
          if (exp_wr_q.size() == 0) check("wr_unexpected_drop", 1, 0);
          else begin check("wr_drop_len", len_of(exp_wr_q[0]), 0); void'(exp_wr_q.pop_front()); end
        end else begin
          if (exp_rd_q.size() == 0) check("rd_unexpected_drop", 1, 0);
          else begin check("rd_drop_len", len_of(exp_rd_q[0]), 0); void'(exp_rd_q.pop_front()); end
        end
      end
      if (cmd_pop && !cmd_stall) begin
        pop_cnt++;
        check("pop_nonempty", cmd_sel ? (fwr_q.size() > 0) : (frd_q.size() > 0), 1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; cmd_stall = 1'b0; rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Cycle index 0 is the cycle of the call; returns the first index with the
  // channel's valid high (-1 if never). stall_mask bit i drives cycle i.
  task automatic watch(input bit ch, input int budget, input logic [31:0] stall_mask,
                       output int first);
    first = -1;
    for (int i = 0; i < budget && i < 32; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      cmd_stall = stall_mask[i];
      @(negedge clk);
      if (ch ? wr_cmd_valid : rd_cmd_valid) begin first = i; break; end
    end
    cmd_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, p0, d0, v0, o0;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    rst_n = 1'b0; cmd_stall = 1'b0; rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    #12;
    check("rst_pop", cmd_pop, 0);
    check("rst_lsb", cmd_lsb, 0);
    check("rst_sel", cmd_sel, 0);
    check("rst_drop", cmd_drop, 0);
    check("rst_rd_valid", rd_cmd_valid, 0);
    check("rst_wr_valid", wr_cmd_valid, 0);
    check("rst_rd_addr", rd_cmd_addr, 0);
    check("rst_rd_len", rd_cmd_len, 0);
    check("rst_wr_addr", wr_cmd_addr, 0);
    check("rst_wr_len", wr_cmd_len, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic fetch: the IDLE decision is at index 1, valid at index 5 (N+4).
    p0 = pop_cnt;
    @(posedge clk); #1;
    push(0, 32'h1000_0000, 32'h0000_0040);
    watch(0, 20, 32'h0, first);
    check("basic_latency", first, 5);
    check("basic_addr", rd_cmd_addr, 32'h1000_0000);
    check("basic_len", rd_cmd_len, 16'h0040);
    idle(4);
    check("basic_pops", pop_cnt - p0, 1);
    check("basic_drained", exp_rd_q.size(), 0);

    // Arbitration: rd first after reset, then alternating.
    do_reset();
    p0 = pop_cnt; o0 = hs_order.size();
    @(posedge clk); #1;
    push(0, 32'h0000_1000, 32'h0000_0010);
    push(0, 32'h0000_2000, 32'h0000_0020);
    push(1, 32'h8000_1000, 32'h0000_0030);
    push(1, 32'h8000_2000, 32'h0000_0040);
    idle(30);
    check("arb_count", hs_order.size() - o0, 4);
    for (int k = 0; k < 4; k++)
      if (hs_order.size() > o0 + k) check($sformatf("arb_order%0d", k), hs_order[o0 + k], exp_order[k]);
    check("arb_pops", pop_cnt - p0, 4);

    // Stall: 3 cycles in REQ_LO (idx 2..4), 2 in REQ_HI (idx 6..7) -> valid at N+9.
    do_reset();
    p0 = pop_cnt;
    @(posedge clk); #1;
    push(0, 32'h2000_0100, 32'h0000_0123);
    watch(0, 24, 32'h0000_00DC, first);
    check("stall_latency", first, 10);
    check("stall_addr", rd_cmd_addr, 32'h2000_0100);
    check("stall_len", rd_cmd_len, 16'h0123);
    idle(4);
    check("stall_pops", pop_cnt - p0, 1);

    // Backpressure on wr: rd still flows, wr holds its first command.
    do_reset();
    wr_cmd_ready = 1'b0;
    p0 = pop_cnt;
    push(1, 32'hA000_0000, 32'h0000_0100);
    push(1, 32'hA000_1000, 32'h0000_0200);
    push(1, 32'hA000_2000, 32'h0000_0300);
    push(0, 32'hB000_0000, 32'h0000_0011);
    push(0, 32'hB000_1000, 32'h0000_0022);
    idle(40);
    check("bp_rd_delivered", exp_rd_q.size(), 0);
    check("bp_wr_valid", wr_cmd_valid, 1);
    check("bp_wr_addr", wr_cmd_addr, 32'hA000_0000);
    check("bp_wr_len", wr_cmd_len, 16'h0100);
    check("bp_pops", pop_cnt - p0, 3);
    check("bp_wr_fifo_left", fwr_q.size(), 2);
    wr_cmd_ready = 1'b1;
    idle(40);
    check("bp_wr_drained", exp_wr_q.size(), 0);
    check("bp_pops_total", pop_cnt - p0, 5);

    // Zero length (upper bits ignored), then a non-zero length with junk upper bits.
    do_reset();
    p0 = pop_cnt; d0 = drop_cnt; v0 = rd_vcyc;
    @(posedge clk); #1;
    push(0, 32'h2000_0000, 32'hFFFF_0000);
    idle(12);
    check("zero_drops", drop_cnt - d0, 1);
    check("zero_no_valid", rd_vcyc - v0, 0);
    check("zero_pops", pop_cnt - p0, 1);
    check("zero_drained", exp_rd_q.size(), 0);
    push(1, 32'h3000_0010, 32'hABCD_0040);
    watch(1, 20, 32'h0, first);
    check("trunc_latency", first, 5);
    check("trunc_len", wr_cmd_len, 16'h0040);
    idle(4);

    // Reset in REQ_HI: pop drops at once, no pop taken, head refetched after release.
    do_reset();
    p0 = pop_cnt;
    @(posedge clk); #1;
    push(0, 32'h4000_0000, 32'h0000_0010);
    push(0, 32'h4000_1000, 32'h0000_0020);
    idle(3);
    check("rstmid_pop_before", cmd_pop, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_pop", cmd_pop, 0);
    check("rstmid_lsb", cmd_lsb, 0);
    check("rstmid_rd_valid", rd_cmd_valid, 0);
    check("rstmid_rd_addr", rd_cmd_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rstmid_no_pop", pop_cnt - p0, 0);
    check("rstmid_fifo_kept", frd_q.size(), 2);
    watch(0, 20, 32'h0, first);
    check("rstmid_latency", first, 4);
    check("rstmid_addr", rd_cmd_addr, 32'h4000_0000);
    check("rstmid_len", rd_cmd_len, 16'h0010);
    idle(12);
    check("rstmid_pops", pop_cnt - p0, 2);
    check("final_rd_drained", exp_rd_q.size(), 0);
    check("final_wr_drained", exp_wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
